stream_demux: RTL

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_pkg.sv | 13 +
 rtl/demux_fifo2.sv | 43 ++++
 rtl/stream_demux.sv | 72 +++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: FIFO depth, occupancy type
// and the destination range check.
package stream_demux_pkg;

  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] count_t;

  function automatic logic sel_in_range(input int sel, input int ports);
    return sel < ports;
  endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry in-order FIFO with 1-bit wrapping pointers and an occupancy count.
// Storage is deliberately not reset; only count and pointers are.
module demux_fifo2
  import stream_demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output count_t        count
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/stream_demux.sv
// Routes an upstream word stream to one of N downstream ports through a 2-entry
// FIFO; words addressed to a nonexistent port are consumed and flagged on err.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  input  logic [WIDTH-1:0]     up_data,
  input  logic [$clog2(N)-1:0] up_sel,
  output logic                 up_ready,
  output logic [N-1:0]         down_valid,
  output logic [WIDTH-1:0]     down_data,
  input  logic [N-1:0]         down_ready,
  output logic                 err
);

  localparam int SW = $clog2(N);

  count_t              count;
  logic [WIDTH+SW-1:0] head;
  logic [SW-1:0]       head_sel;
  logic                has_head;
  logic                accept;
  logic                in_range;
  logic                push;
  logic                pop;
  logic                err_q;

  // Ready depends only on stored occupancy so upstream never sees a path from down_ready.
  assign up_ready = !rst && (count < count_t'(FIFO_DEPTH));
  assign accept   = up_valid && up_ready;
  assign in_range = sel_in_range(int'(up_sel), N);
  assign push     = accept && in_range;

  assign head_sel  = head[SW-1:0];
  assign down_data = head[WIDTH+SW-1:SW];
  assign has_head  = !rst && (count != '0);

  always_comb begin
    down_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (has_head && (head_sel == SW'(i))) down_valid[i] = 1'b1;
    end
  end

  // Only the head's own port can pop it, which gives strict head-of-line ordering.
  assign pop = |(down_valid & down_ready);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept && !in_range;
  end

  assign err = err_q && !rst;

  demux_fifo2 #(
    .DW(WIDTH + SW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({up_data, up_sel}),
    .rdata (head),
    .count (count)
  );

endmodule
